// File: rtl/frame_pkg.sv
// Shared definitions for the frame loader slice.
//   - state_t   : loader FSM state encoding (3 bits)
//   - FRAME_LEN : number of words packed into one frame
//   - CNT_W     : width of the external frame counter / buffer address
package frame_pkg;

  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 3;

  typedef enum logic [2:0] {
    S_ALIGN = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/frame_buffer.sv
// Frame storage: FRAME_LEN words of DATA_W bits.
// Ports:
//   clk    in   single clock
//   rst_n  in   synchronous active-low clear of every word
//   we     in   write enable
//   addr   in   word index to write
//   wdata  in   word to write
//   rdata  out  all words packed, word 0 in the LSBs
module frame_buffer
  import frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [CNT_W-1:0]              addr,
  input  logic [DATA_W-1:0]             wdata,
  output logic [FRAME_LEN*DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem_q [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_LEN; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < FRAME_LEN; i++) rdata[i*DATA_W +: DATA_W] = mem_q[i];
  end

endmodule

// File: rtl/frame_loader.sv
// Upstream controller for an external 3-bit frame counter. Accepts words over
// valid/ready, steps the counter once per accepted word and uses its value as
// the buffer address. After a full frame it verifies the counter wrapped and
// offers the packed frame downstream over valid/ready.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   start            begin a frame (only looked at in IDLE)
//   in_valid/in_data/in_ready   input word stream
//   count, co        counter value and registered carry from the counter
//   count_enable     combinational increment request to the counter
//   out_valid/out_data/out_ready  packed frame stream
//   busy             loader not idle
//   err              sticky flag: counter did not wrap at a frame end
module frame_loader
  import frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic [CNT_W-1:0]              count,
  input  logic                          co,
  output logic                          count_enable,
  output logic                          out_valid,
  output logic [FRAME_LEN*DATA_W-1:0]   out_data,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          err
);

  state_t state_q, state_d;
  logic   err_q, err_d;
  logic   buf_we;

  frame_buffer #(.DATA_W(DATA_W)) u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .addr  (count),
    .wdata (in_data),
    .rdata (out_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_ALIGN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Every output is forced low while reset is held, so the counter cannot be
  // stepped and no handshake can complete before ALIGN runs.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    count_enable = 1'b0;
    buf_we       = 1'b0;
    if (rst_n) begin
      case (state_q)
        // The counter has no reset; walk it forward until it reads zero.
        S_ALIGN: begin
          if (count != '0) count_enable = 1'b1;
          else             state_d      = S_IDLE;
        end
        S_IDLE: begin
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            buf_we       = 1'b1;
            count_enable = 1'b1;
            if (count == CNT_W'(FRAME_LEN - 1)) state_d = S_CHECK;
          end
        end
        // After the eighth increment the counter must have wrapped to zero
        // and raised its carry; anything else means the address got out of step.
        S_CHECK: begin
          if (!(co && count == '0)) err_d = 1'b1;
          state_d = S_OUT;
        end
        S_OUT: begin
          out_valid = 1'b1;
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_ALIGN;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

endmodule
